// File: rtl/pea_horner_eval_if.sv
// Request/response bundle for pea_horner_eval: coefficient write port, evaluation
// request and result/status FIFO write side.
interface pea_horner_eval_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned MAX_DEG   = 10,
  parameter int unsigned NUM_BANKS = 4
);
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned IW = $clog2(MAX_DEG + 1);

  logic                 coef_wr;
  logic [BW-1:0]        coef_bank;
  logic [IW-1:0]        coef_idx;
  logic [WIDTH-1:0]     coef_data;
  logic                 coef_err;
  logic                 start;
  logic [BW-1:0]        bank_sel;
  logic [IW:0]          degree;
  logic [WIDTH-1:0]     x_in;
  logic                 busy;
  logic                 out_full;
  logic                 wr_out;
  logic [ACC_WIDTH-1:0] data_out_result;
  logic [WIDTH-1:0]     data_out_status;

  modport master (
    output coef_wr, coef_bank, coef_idx, coef_data, start, bank_sel, degree, x_in, out_full,
    input  coef_err, busy, wr_out, data_out_result, data_out_status
  );

  modport slave (
    input  coef_wr, coef_bank, coef_idx, coef_data, start, bank_sel, degree, x_in, out_full,
    output coef_err, busy, wr_out, data_out_result, data_out_status
  );
endinterface

// File: rtl/pea_horner_eval.sv
// Banked-coefficient polynomial evaluator using Horner's rule, one MAC per cycle.
// Define PEA_SATURATE_EN to clamp overflowing steps instead of wrapping.
module pea_horner_eval #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned MAX_DEG   = 10,
  parameter int unsigned NUM_BANKS = 4
) (
  input logic clk,
  input logic rst,
  pea_horner_eval_if.slave bus
);
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned IW = $clog2(MAX_DEG + 1);
  localparam int unsigned DW = IW + 1;
  localparam int unsigned PW = 2 * ACC_WIDTH;

  typedef enum logic [1:0] {StIdle, StInit, StMac, StWrite} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] coef_mem [NUM_BANKS][MAX_DEG+1];

  logic [BW-1:0]               bank_q;
  logic [DW-1:0]               deg_q, cnt_q;
  logic [WIDTH-1:0]            x_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_next;
  logic                        ovf_q, deg_err_q, coef_err_q;

  logic                 deg_bad, bank_locked, coef_accept;
  logic [IW-1:0]        rd_idx;
  logic [WIDTH-1:0]     coef_rd;
  logic signed [PW-1:0] acc_ext, x_ext, c_ext, sum_full;
  logic                 step_ovf;

  assign deg_bad     = deg_q > DW'(MAX_DEG);
  // The captured bank is frozen only while an evaluation is in flight.
  assign bank_locked = (state_q != StIdle) && (bus.coef_bank == bank_q);
  assign coef_accept = bus.coef_wr && (bus.coef_idx <= IW'(MAX_DEG)) && !bank_locked;

  always_ff @(posedge clk) begin
    if (coef_accept) coef_mem[bus.coef_bank][bus.coef_idx] <= bus.coef_data;
  end

  assign rd_idx  = (state_q == StInit) ? deg_q[IW-1:0] : IW'(cnt_q - DW'(1));
  assign coef_rd = coef_mem[bank_q][rd_idx];

  always_comb begin
    acc_ext  = {{(PW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    x_ext    = {{(PW-WIDTH){x_q[WIDTH-1]}}, x_q};
    c_ext    = {{(PW-WIDTH){coef_rd[WIDTH-1]}}, coef_rd};
    sum_full = acc_ext * x_ext + c_ext;
    step_ovf = sum_full != {{(PW-ACC_WIDTH){sum_full[ACC_WIDTH-1]}}, sum_full[ACC_WIDTH-1:0]};
`ifdef PEA_SATURATE_EN
    if (step_ovf) begin
      acc_next = sum_full[PW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_next = sum_full[ACC_WIDTH-1:0];
    end
`else
    acc_next = sum_full[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d     = state_q;
    bus.busy    = state_q != StIdle;
    bus.wr_out  = 1'b0;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StInit;
      StInit:  state_d = (deg_bad || deg_q == '0) ? StWrite : StMac;
      StMac:   if (cnt_q == DW'(1)) state_d = StWrite;
      StWrite: begin
        if (!bus.out_full) begin
          bus.wr_out = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bank_q     <= '0;
      deg_q      <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      deg_err_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_err_q <= bus.coef_wr && !coef_accept;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            bank_q <= bus.bank_sel;
            deg_q  <= bus.degree;
            x_q    <= bus.x_in;
          end
        end
        StInit: begin
          ovf_q     <= 1'b0;
          deg_err_q <= deg_bad;
          if (deg_bad) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else begin
            acc_q <= {{(ACC_WIDTH-WIDTH){coef_rd[WIDTH-1]}}, coef_rd};
            cnt_q <= deg_q;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | step_ovf;
          cnt_q <= cnt_q - DW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.data_out_status          = '0;
    bus.data_out_status[0]       = (state_q == StWrite) && !deg_err_q;
    bus.data_out_status[1]       = ovf_q;
    bus.data_out_status[2]       = deg_err_q;
    bus.data_out_status[4 +: BW] = bank_q;
  end

  assign bus.data_out_result = acc_q;
  assign bus.coef_err        = coef_err_q;
endmodule

// File: tb/tb_pea_horner_eval.sv
// Directed self-checking bench for pea_horner_eval (default parameters).
module tb_pea_horner_eval;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  pea_horner_eval_if #(.WIDTH(16), .ACC_WIDTH(32), .MAX_DEG(10), .NUM_BANKS(4)) bus ();

  pea_horner_eval #(.WIDTH(16), .ACC_WIDTH(32), .MAX_DEG(10), .NUM_BANKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic write_coef(input logic [1:0] bank, input logic [3:0] idx, input logic [15:0] d);
    @(negedge clk);
    bus.coef_wr   = 1'b1;
    bus.coef_bank = bank;
    bus.coef_idx  = idx;
    bus.coef_data = d;
    @(posedge clk);
    #1 bus.coef_wr = 1'b0;
  endtask

  // Issues one request and returns latency (start cycle = 0) and the values seen with wr_out.
  task automatic do_eval(input logic [1:0] bank, input logic [4:0] deg, input logic [15:0] x,
                         output int lat, output logic [31:0] res, output logic [15:0] stat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bank_sel = bank;
    bus.degree   = deg;
    bus.x_in     = x;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 1;
    while (bus.wr_out !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    res  = bus.data_out_result;
    stat = bus.data_out_status;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++; if (bus.wr_out !== 1'b0) $display("FAIL reset_wr_out got %b want 0", bus.wr_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.coef_err !== 1'b0) $display("FAIL reset_coef_err got %b want 0", bus.coef_err);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out_result !== 32'h0)
      $display("FAIL reset_result got %h want 0", bus.data_out_result);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out_status !== 16'h0)
      $display("FAIL reset_status got %h want 0", bus.data_out_status);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] res; logic [15:0] stat;
    write_coef(2'd0, 4'd0, 16'd1);
    write_coef(2'd0, 4'd1, 16'd2);
    write_coef(2'd0, 4'd2, 16'd3);
    do_eval(2'd0, 5'd2, 16'd2, lat, res, stat);
    total_cnt++; if (lat != 4) $display("FAIL basic_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (res !== 32'd17) $display("FAIL basic_result got %0d want 17", res);
    else pass_cnt++;
    total_cnt++; if (stat !== 16'h0001) $display("FAIL basic_status got %h want 0001", stat);
    else pass_cnt++;
  endtask

  task automatic test_degree_zero();
    int lat; logic [31:0] res; logic [15:0] stat;
    write_coef(2'd2, 4'd0, 16'hFFFB);
    do_eval(2'd2, 5'd0, 16'd7, lat, res, stat);
    total_cnt++; if (lat != 2) $display("FAIL deg0_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (res !== 32'hFFFF_FFFB) $display("FAIL deg0_result got %h want fffffffb", res);
    else pass_cnt++;
    total_cnt++; if (stat !== 16'h0021) $display("FAIL deg0_status got %h want 0021", stat);
    else pass_cnt++;
  endtask

  task automatic test_degree_error();
    int lat; logic [31:0] res; logic [15:0] stat;
    do_eval(2'd1, 5'd11, 16'd3, lat, res, stat);
    total_cnt++; if (lat != 2) $display("FAIL degerr_latency got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (res !== 32'h0) $display("FAIL degerr_result got %h want 0", res);
    else pass_cnt++;
    total_cnt++; if (stat !== 16'h0014) $display("FAIL degerr_status got %h want 0014", stat);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] res; logic [15:0] stat; logic [31:0] exp_res;
`ifdef PEA_SATURATE_EN
    exp_res = 32'h7FFF_FFFF;
`else
    exp_res = 32'h8000_8000;  // low word of 0x1FFF_8000_8000
`endif
    write_coef(2'd0, 4'd0, 16'h0000);
    write_coef(2'd0, 4'd1, 16'h7FFF);
    write_coef(2'd0, 4'd2, 16'h7FFF);
    do_eval(2'd0, 5'd2, 16'h7FFF, lat, res, stat);
    total_cnt++; if (lat != 4) $display("FAIL ovf_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (res !== exp_res) $display("FAIL ovf_result got %h want %h", res, exp_res);
    else pass_cnt++;
    total_cnt++; if (stat[1] !== 1'b1) $display("FAIL ovf_status_bit1 got %b want 1", stat[1]);
    else pass_cnt++;
  endtask

  task automatic test_out_full_and_lock();
    int lat; logic [31:0] res; logic [15:0] stat; int early;
    write_coef(2'd3, 4'd0, 16'd4);
    write_coef(2'd3, 4'd1, 16'hFFFF);
    @(negedge clk);
    bus.out_full = 1'b1;
    bus.start    = 1'b1;
    bus.bank_sel = 2'd3;
    bus.degree   = 5'd1;
    bus.x_in     = 16'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    bus.coef_wr = 1'b1; bus.coef_bank = 2'd3; bus.coef_idx = 4'd0; bus.coef_data = 16'd99;
    @(posedge clk);
    #1 bus.coef_wr = 1'b0;
    total_cnt++;
    if (bus.coef_err !== 1'b1) $display("FAIL locked_bank_coef_err got %b want 1", bus.coef_err);
    else pass_cnt++;
    @(negedge clk);
    bus.coef_wr = 1'b1; bus.coef_bank = 2'd1; bus.coef_idx = 4'd5; bus.coef_data = 16'd7;
    @(posedge clk);
    #1 bus.coef_wr = 1'b0;
    total_cnt++;
    if (bus.coef_err !== 1'b0) $display("FAIL other_bank_coef_err got %b want 0", bus.coef_err);
    else pass_cnt++;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.wr_out !== 1'b0 || bus.busy !== 1'b1) early++;
      @(posedge clk);
      #1;
    end
    total_cnt++; if (early != 0) $display("FAIL full_hold got %0d bad cycles want 0", early);
    else pass_cnt++;
    @(negedge clk);
    bus.out_full = 1'b0;
    #1;
    total_cnt++; if (bus.wr_out !== 1'b1) $display("FAIL full_release got %b want 1", bus.wr_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.data_out_result !== 32'd1)
      $display("FAIL full_result got %0d want 1", bus.data_out_result);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.wr_out !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL single_pulse got wr_out=%b busy=%b want 0 0", bus.wr_out, bus.busy);
    else pass_cnt++;
    write_coef(2'd0, 4'd11, 16'd1);
    total_cnt++;
    if (bus.coef_err !== 1'b1) $display("FAIL bad_idx_coef_err got %b want 1", bus.coef_err);
    else pass_cnt++;
    do_eval(2'd3, 5'd1, 16'd3, lat, res, stat);
    total_cnt++; if (res !== 32'd1) $display("FAIL locked_value_kept got %0d want 1", res);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    int lat; logic [31:0] res;
    @(negedge clk);
    bus.coef_wr = 1'b1; bus.coef_bank = 2'd3; bus.coef_idx = 4'd0; bus.coef_data = 16'd10;
    bus.start = 1'b1; bus.bank_sel = 2'd3; bus.degree = 5'd1; bus.x_in = 16'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.coef_wr = 1'b0;
    lat = 1;
    while (bus.wr_out !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    res = bus.data_out_result;
    total_cnt++; if (res !== 32'd7) $display("FAIL same_cycle_result got %0d want 7", res);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic [15:0] stat; int pulses;
    write_coef(2'd0, 4'd0, 16'd1);
    write_coef(2'd0, 4'd1, 16'd2);
    write_coef(2'd0, 4'd2, 16'd3);
    @(negedge clk);
    bus.start = 1'b1; bus.bank_sel = 2'd0; bus.degree = 5'd2; bus.x_in = 16'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || bus.wr_out !== 1'b0 || bus.coef_err !== 1'b0 ||
        bus.data_out_result !== 32'h0 || bus.data_out_status !== 16'h0)
      $display("FAIL mid_reset_outputs got busy=%b wr=%b err=%b res=%h st=%h want all 0",
               bus.busy, bus.wr_out, bus.coef_err, bus.data_out_result, bus.data_out_status);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 if (bus.wr_out === 1'b1) pulses++;
    end
    total_cnt++; if (pulses != 0) $display("FAIL abort_no_wr_out got %0d want 0", pulses);
    else pass_cnt++;
    do_eval(2'd0, 5'd2, 16'd2, lat, res, stat);
    total_cnt++;
    if (lat != 4 || res !== 32'd17 || stat !== 16'h0001)
      $display("FAIL after_reset_eval got lat=%0d res=%0d st=%h want 4 17 0001", lat, res, stat);
    else pass_cnt++;
  endtask

  initial begin
    bus.coef_wr = 1'b0; bus.coef_bank = '0; bus.coef_idx = '0; bus.coef_data = '0;
    bus.start = 1'b0; bus.bank_sel = '0; bus.degree = '0; bus.x_in = '0; bus.out_full = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_degree_zero();
    test_degree_error();
    test_overflow();
    test_out_full_and_lock();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pea_horner_eval.md
PEA_HORNER_EVAL -- requirements
Module: pea_horner_eval

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: coefficient, x and status word width; legal range 8 to 32.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32: accumulator and result width; legal range WIDTH to 64.
REQ-003 The block SHALL have parameter MAX_DEG, default 10: highest polynomial degree supported.
REQ-004 The block SHALL have parameter NUM_BANKS, default 4: number of independent coefficient banks; power of two, 2 to 16.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 coef_wr  in  1  coefficient write strobe.
REQ-008 coef_bank  in  log2(NUM_BANKS)  bank addressed by coef_wr.
REQ-009 coef_idx  in  log2(MAX_DEG+1)  coefficient index i of c_i.
REQ-010 coef_data  in  WIDTH  coefficient value, two's complement.
REQ-011 coef_err  out  1  one-cycle pulse on a rejected coefficient write.
REQ-012 start  in  1  evaluation request strobe.
REQ-013 bank_sel  in  log2(NUM_BANKS)  bank used by the request.
REQ-014 degree  in  log2(MAX_DEG+1)+1  polynomial degree N.
REQ-015 x_in  in  WIDTH  evaluation point, two's complement.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 out_full  in  1  downstream result/status FIFO cannot accept a word.
REQ-018 wr_out  out  1  one-cycle write strobe to the result and status FIFOs.
REQ-019 data_out_result  out  ACC_WIDTH  polynomial value.
REQ-020 data_out_status  out  WIDTH  status word: bit0 ok, bit1 overflow, bit2 degree error, bits[7:4] bank_sel, remaining bits 0.

Function
REQ-021 The FSM SHALL have states IDLE, INIT, MAC and WRITE.
REQ-022 IDLE->INIT on start; the block captures bank_sel, degree and x_in; start is ignored while busy.
REQ-023 If degree > MAX_DEG, INIT SHALL go directly to WRITE with result 0 and status bit2 set; the coefficient RAM is not read.
REQ-024 In INIT: acc <= sign-extended c_N; cnt <= N; go to WRITE if N=0, else go to MAC.
REQ-025 Each MAC cycle: acc <= acc*x + c_(cnt-1); cnt decrements; MAC->WRITE after the cycle that uses c_0.
REQ-026 Arithmetic is signed; the product and sum SHALL be computed at 2*ACC_WIDTH and truncated to ACC_WIDTH.
REQ-027 Any truncation that changes the value SHALL set a sticky overflow bit; the bit is cleared in INIT.
REQ-028 In WRITE with out_full=0: wr_out=1 for one cycle, with result and status valid in that same cycle, then WRITE->IDLE.
REQ-029 In WRITE with out_full=1: hold state, wr_out=0, outputs stable.
REQ-030 Latency from start to wr_out SHALL be N+2 cycles with out_full=0; degree error SHALL take 2 cycles.
REQ-031 A coef_wr to any bank other than the captured bank SHALL be accepted in any state.
REQ-032 A coef_wr to the captured bank while busy SHALL be dropped, with coef_err pulsed in the following cycle.
REQ-033 A coef_wr with coef_idx > MAX_DEG SHALL be dropped, with coef_err pulsed in the following cycle.
REQ-034 On a start and a coef_wr to the same bank in the same cycle, the write SHALL take effect first, so the evaluation uses the new value.

Reset
REQ-035 rst SHALL force IDLE, busy=0, wr_out=0, coef_err=0, data_out_result=0, data_out_status=0, acc=0 and cnt=0.
REQ-036 Coefficient banks SHALL NOT be reset; their contents are undefined until written.
REQ-037 rst asserted mid-evaluation SHALL abort the evaluation without a wr_out pulse; the first start after release SHALL operate normally.

Configuration
REQ-038 With macro PEA_SATURATE_EN defined, an overflowing step SHALL clamp acc to the signed ACC_WIDTH max or min according to the true sign, and set bit1.
REQ-039 Without PEA_SATURATE_EN, acc SHALL wrap modulo 2^ACC_WIDTH, and bit1 is still reported.

Verification
REQ-040 Bank0 = {c0=1, c1=2, c2=3}, start N=2, x=2 -> wr_out at cycle 4, result 17, status 0x001.
REQ-041 Bank2 c0=-5, start N=0, x=7 -> wr_out at cycle 2, result -5, status 0x021.
REQ-042 start with degree=MAX_DEG+1 on bank1 -> wr_out at cycle 2, result 0, status 0x014.
REQ-043 Bank0 {c0=0, c1=0x7FFF, c2=0x7FFF}, x=0x7FFF, N=2 -> status bit1 set; result clamped to 0x7FFFFFFF with PEA_SATURATE_EN, wrapped value without it.
REQ-044 out_full held high 5 cycles in WRITE -> no wr_out while high, a single wr_out on release; coef_wr to the busy bank -> coef_err pulse, value unchanged.
REQ-045 rst pulsed during MAC -> no wr_out, all outputs 0; the next evaluation is correct.
